// File: rtl/game_round_controller_pkg.sv
//------------------------------------------------------------------------------
// Module      : game_round_controller_pkg
// Description : Shared state encodings, scan codes and score helper for the
//               tic-tac-toe round controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package game_round_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PLAY  = 3'd2,
        ST_WIN   = 3'd3,
        ST_DRAW  = 3'd4
    } state_e;

    localparam logic [7:0] c_KEY_ENTER  = 8'h5A;
    localparam logic [7:0] c_KEY_ESCAPE = 8'h76;
    localparam logic [7:0] c_KEY_BREAK  = 8'hF0;

    localparam logic [3:0] c_SCORE_MAX = 4'd9;
    localparam logic [3:0] c_TURN_LAST = 4'd9;

    // BCD score digit, held at 9 once reached.
    function automatic logic [3:0] score_inc(input logic [3:0] score);
        return (score >= c_SCORE_MAX) ? c_SCORE_MAX : score + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_round_controller_hold_timer.sv
//------------------------------------------------------------------------------
// Module      : round_hold_timer
// Description : Blink half-period counter plus toggle counter that signals the
//               end of the win/draw display.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module round_hold_timer #(
    parameter int BLINK_CYCLES = 12500000,
    parameter int HOLD_TOGGLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic tick,
    output logic phase,
    output logic done
);

    localparam int c_BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int c_TOG_W   = $clog2(HOLD_TOGGLES + 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [c_TOG_W-1:0]   c_TOG_LAST   = c_TOG_W'(HOLD_TOGGLES - 1);

    logic [c_BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [c_TOG_W-1:0]   tog_cnt_q, tog_cnt_d;
    logic                 phase_q, phase_d;
    logic                 wrap;

    assign wrap  = (blink_cnt_q == c_BLINK_LAST);
    // done does not look at start, so the parent's start logic may depend on it.
    assign done  = tick && wrap && (tog_cnt_q == c_TOG_LAST);
    assign phase = phase_q;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        tog_cnt_d   = tog_cnt_q;
        phase_d     = phase_q;
        if (start) begin
            blink_cnt_d = '0;
            tog_cnt_d   = '0;
            phase_d     = 1'b0;
        end else if (tick) begin
            if (wrap) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
                tog_cnt_d   = tog_cnt_q + 1'b1;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            tog_cnt_q   <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            tog_cnt_q   <= tog_cnt_d;
            phase_q     <= phase_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_round_controller.sv
//------------------------------------------------------------------------------
// Module      : game_round_controller
// Description : Round sequencing, scoring and keyboard command decode for the
//               tic-tac-toe game.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module game_round_controller
    import game_round_controller_pkg::*;
#(
    parameter int BLINK_CYCLES = 12500000,
    parameter int HOLD_TOGGLES = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iKeyboardFlag,
    input  logic       iWinFlag,
    input  logic [3:0] iTurnCounter,
    output logic       oBoardClear,
    output logic       oInputEnable,
    output logic       oBlinkPhase,
    output logic [3:0] oScoreX,
    output logic [3:0] oScoreO,
    output logic [2:0] oState
);

    state_e     state_q, state_d;
    logic [3:0] score_x_q, score_x_d;
    logic [3:0] score_o_q, score_o_d;
    logic       break_q, break_d;

    logic key_valid, key_enter, key_escape;
    logic in_hold, hold_start, hold_phase, hold_done;

    // A byte following 0xF0 is the release of a key and is never a command.
    assign key_valid  = iKeyboardFlag && !break_q;
    assign key_enter  = key_valid && (iData == c_KEY_ENTER);
    assign key_escape = key_valid && (iData == c_KEY_ESCAPE);

    assign in_hold    = (state_q == ST_WIN) || (state_q == ST_DRAW);
    assign hold_start = (state_q == ST_PLAY) &&
                        ((state_d == ST_WIN) || (state_d == ST_DRAW));

    round_hold_timer #(
        .BLINK_CYCLES (BLINK_CYCLES),
        .HOLD_TOGGLES (HOLD_TOGGLES)
    ) u_hold_timer (
        .clk   (Clock),
        .rst   (Reset),
        .start (hold_start),
        .tick  (in_hold),
        .phase (hold_phase),
        .done  (hold_done)
    );

    always_comb begin
        state_d   = state_q;
        score_x_d = score_x_q;
        score_o_d = score_o_q;
        break_d   = break_q;

        if (iKeyboardFlag) begin
            break_d = break_q ? 1'b0 : (iData == c_KEY_BREAK);
        end

        case (state_q)
            ST_IDLE: begin
                if (key_enter) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (iWinFlag) begin
                    state_d = ST_WIN;
                    // X moves first, so an odd mark count means X placed the last mark.
                    if (iTurnCounter[0]) score_x_d = score_inc(score_x_q);
                    else                 score_o_d = score_inc(score_o_q);
                end else if (iTurnCounter == c_TURN_LAST) begin
                    state_d = ST_DRAW;
                end
            end
            ST_WIN, ST_DRAW: begin
                if (key_enter || hold_done) state_d = ST_CLEAR;
            end
            default: state_d = ST_IDLE;
        endcase

        if (key_escape) begin
            state_d   = ST_IDLE;
            score_x_d = '0;
            score_o_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            score_x_q <= '0;
            score_o_q <= '0;
            break_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_x_q <= score_x_d;
            score_o_q <= score_o_d;
            break_q   <= break_d;
        end
    end

    assign oBoardClear  = (state_q == ST_CLEAR);
    assign oInputEnable = (state_q == ST_PLAY);
    assign oBlinkPhase  = in_hold && hold_phase;
    assign oScoreX      = score_x_q;
    assign oScoreO      = score_o_q;
    assign oState       = state_q;

endmodule

`default_nettype wire
